// File: rtl/dtc_loc_rx.sv
// Local write bus receiver: DATA/CTRL register window feeding a FIFO; head drains over valid/ready.
// Push-to-head latency 1 cycle; a full FIFO drops DATA writes (sticky ovf) unless a pop frees a slot that cycle.
module dtc_loc_rx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          dadd_in_en,
  input  logic [31:0]                   dadd_in_addr,
  input  logic [31:0]                   dadd_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic                          ctrl_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf,
  output logic [15:0]                   err_cnt
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          LW        = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [31:0] DATA_ADDR = BASE_ADDR;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'h4;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ctrl_en_q, ctrl_en_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic is_data, is_ctrl, bad_addr;
  logic pop, push, flush, space, err_inc;

  always_comb begin
    is_data  = dadd_in_en && (dadd_in_addr == DATA_ADDR);
    is_ctrl  = dadd_in_en && (dadd_in_addr == CTRL_ADDR);
    bad_addr = dadd_in_en && !is_data && !is_ctrl;
    pop      = (level_q != '0) && out_ready;
    flush    = is_ctrl && dadd_in[1];
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    space    = (level_q < FULL_LVL) || pop;
    push     = is_data && ctrl_en_q && space;
    err_inc  = bad_addr || (is_data && !push);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ctrl_en_d = ctrl_en_q;
    ovf_d     = ovf_q;
    err_cnt_d = err_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end

    if (is_ctrl) ctrl_en_d = dadd_in[0];
    if (is_data && ctrl_en_q && !space) ovf_d = 1'b1;
    if (err_inc && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ctrl_en_q <= 1'b0;
      ovf_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= dadd_in;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ctrl_en_q <= ctrl_en_d;
      ovf_q     <= ovf_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign ctrl_en    = ctrl_en_q;
  assign fifo_level = level_q;
  assign ovf        = ovf_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_dtc_loc_rx.sv
// Directed bench for dtc_loc_rx with hand-computed expectations.
module tb_dtc_loc_rx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] DATA  = BASE;
  localparam logic [31:0] CTRL  = BASE + 32'h4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dadd_in_en = 1'b0;
  logic [31:0] dadd_in_addr = '0;
  logic [31:0] dadd_in = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        ctrl_en;
  logic [3:0]  fifo_level;
  logic        ovf;
  logic [15:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  dtc_loc_rx #(.FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .dadd_in_en(dadd_in_en), .dadd_in_addr(dadd_in_addr),
    .dadd_in(dadd_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ctrl_en(ctrl_en), .fifo_level(fifo_level), .ovf(ovf), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dadd_in_en = 1'b1; dadd_in_addr = a; dadd_in = d;
    tick();
    dadd_in_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_ctrl"}, ctrl_en, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_ovf"}, ovf, 0);
    check({tag, "_err"}, err_cnt, 0);
  endtask

  logic [31:0] exp_q[$];

  initial begin
    // Reset state
    reset = 1'b1;
    tick(); tick();
    check_reset_state("rst");
    reset = 1'b0;

    // Streaming with out_ready=1: each word on the head one cycle after its write
    out_ready = 1'b1;
    wr(CTRL, 32'h1);
    check("t1_ctrl_en", ctrl_en, 1);
    for (int i = 0; i < 4; i++) begin
      dadd_in_en = 1'b1; dadd_in_addr = DATA; dadd_in = 32'hA0 + i;
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 32'hA0 + i);
      check("t1_level", fifo_level, 1);
    end
    dadd_in_en = 1'b0;
    tick();
    check("t1_empty", out_valid, 0);
    check("t1_err", err_cnt, 0);

    // Overfill with out_ready=0: 8 accepted, 2 dropped; head stable while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr(DATA, 32'h10 + i);
      check("t2_hold", out_data, 32'h10);
    end
    check("t2_level", fifo_level, 8);
    check("t2_ovf", ovf, 1);
    check("t2_err", err_cnt, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_drain", out_data, 32'h10 + i);
      tick();
    end
    check("t2_drained", out_valid, 0);
    check("t2_ovf_sticky", ovf, 1);

    // Flush clears ovf; full FIFO accepts a write in a pop cycle
    wr(CTRL, 32'h3);
    check("t3_ovf_clr", ovf, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(DATA, 32'h30 + i);
    check("t3_full", fifo_level, 8);
    out_ready = 1'b1;
    wr(DATA, 32'h55);
    check("t3_level_keep", fifo_level, 8);
    check("t3_ovf_keep", ovf, 0);
    exp_q = {32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36, 32'h37, 32'h55};
    for (int i = 0; i < 8; i++) begin
      check("t3_order", out_data, exp_q[i]);
      tick();
    end
    check("t3_empty", out_valid, 0);

    // Wrap-around: 20 words streamed through
    for (int i = 0; i < 20; i++) begin
      dadd_in_en = 1'b1; dadd_in_addr = DATA; dadd_in = 32'h100 + i;
      tick();
      check("wrap_data", out_data, 32'h100 + i);
      check("wrap_level", fifo_level, 1);
    end
    dadd_in_en = 1'b0;
    tick();
    check("wrap_empty", out_valid, 0);
    check("wrap_err", err_cnt, 2);

    // Rejected writes
    wr(CTRL, 32'h0);
    check("t4_ctrl_off", ctrl_en, 0);
    wr(DATA, 32'h99);
    wr(BASE + 32'h8, 32'h1);
    wr(BASE + 32'h2, 32'h1);
    check("t4_err", err_cnt, 5);
    check("t4_valid", out_valid, 0);
    check("t4_ovf", ovf, 0);
    check("t4_ctrl_still_off", ctrl_en, 0);

    // Flush with 5 buffered words and a concurrent pop
    wr(CTRL, 32'h1);
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(DATA, 32'h40 + i);
    check("t5_ovf", ovf, 1);
    check("t5_err", err_cnt, 6);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t5_level5", fifo_level, 5);
    check("t5_head", out_data, 32'h43);
    wr(CTRL, 32'h3);
    check("t5_flush_level", fifo_level, 0);
    check("t5_flush_valid", out_valid, 0);
    check("t5_flush_ovf", ovf, 0);
    check("t5_flush_ctrl", ctrl_en, 1);
    wr(DATA, 32'h77);
    check("t5_after_valid", out_valid, 1);
    check("t5_after_data", out_data, 32'h77);
    tick();
    check("t5_after_empty", out_valid, 0);

    // Reset while 4 words buffered and a write is streaming
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(DATA, 32'h60 + i);
    check("t6_level4", fifo_level, 4);
    dadd_in_en = 1'b1; dadd_in_addr = DATA; dadd_in = 32'h64;
    reset = 1'b1;
    tick();
    check_reset_state("t6_rst");
    dadd_in_en = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    wr(CTRL, 32'h1);
    wr(DATA, 32'h88);
    check("t6_first_valid", out_valid, 1);
    check("t6_first_data", out_data, 32'h88);
    check("t6_err", err_cnt, 0);
    tick();
    check("t6_empty", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
